// File: rtl/otter_decode_stage.sv
// rtl/otter_decode_stage.sv - OTTER ID stage: RF addressing, EX/MEM forwarding, load-use stall, ID/EX register
module otter_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IF_ID_VALID,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic [31:0]     IF_ID_IR,
    output logic [4:0]      RF_ADR1,
    output logic [4:0]      RF_ADR2,
    input  logic [XLEN-1:0] RF_RS1,
    input  logic [XLEN-1:0] RF_RS2,
    input  logic [XLEN-1:0] EX_RESULT,
    input  logic [4:0]      MEM_RD,
    input  logic            MEM_REG_WRITE,
    input  logic [XLEN-1:0] MEM_RESULT,
    input  logic            FLUSH,
    input  logic            HOLD,
    output logic            STALL,
    output logic            ID_EX_VALID,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [31:0]     ID_EX_IR,
    output logic [XLEN-1:0] ID_EX_RS1,
    output logic [XLEN-1:0] ID_EX_RS2,
    output logic [4:0]      ID_EX_RD,
    output logic            ID_EX_REG_WRITE,
    output logic            ID_EX_IS_LOAD
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            writes_rd;
    logic            reg_write;
    logic            is_load;
    logic            ex_fwd_ok;
    logic            load_use;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign opcode  = IF_ID_IR[6:0];
    assign rd      = IF_ID_IR[11:7];
    assign RF_ADR1 = IF_ID_IR[19:15];
    assign RF_ADR2 = IF_ID_IR[24:20];

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_write = writes_rd & (rd != 5'd0);
    assign is_load   = (opcode == OP_LOAD);

    // A load in EX has no data yet; its consumers stall and pick it up from MEM next cycle.
    assign ex_fwd_ok = ID_EX_VALID & ID_EX_REG_WRITE & ~ID_EX_IS_LOAD;

    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      adr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_ok,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data
    );
        if (adr == 5'd0)
            return '0;
        else if (ex_ok && ex_rd == adr)
            return ex_data;
        else if (mem_we && mem_rd == adr)
            return mem_data;
        else
            return rf_data;
    endfunction

    assign op1 = forward(RF_ADR1, RF_RS1, ex_fwd_ok, ID_EX_RD, EX_RESULT,
                         MEM_REG_WRITE, MEM_RD, MEM_RESULT);
    assign op2 = forward(RF_ADR2, RF_RS2, ex_fwd_ok, ID_EX_RD, EX_RESULT,
                         MEM_REG_WRITE, MEM_RD, MEM_RESULT);

    assign load_use = IF_ID_VALID & ID_EX_VALID & ID_EX_IS_LOAD & ID_EX_REG_WRITE &
                      ((use_rs1 & (RF_ADR1 == ID_EX_RD)) |
                       (use_rs2 & (RF_ADR2 == ID_EX_RD)));
    assign STALL    = load_use & ~FLUSH;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ID_EX_VALID     <= 1'b0;
            ID_EX_PC        <= PC_RESET;
            ID_EX_IR        <= NOP;
            ID_EX_RS1       <= '0;
            ID_EX_RS2       <= '0;
            ID_EX_RD        <= 5'd0;
            ID_EX_REG_WRITE <= 1'b0;
            ID_EX_IS_LOAD   <= 1'b0;
        end else if (FLUSH) begin
            // Flush overrides a freeze so a killed instruction can never survive.
            ID_EX_VALID     <= 1'b0;
            ID_EX_REG_WRITE <= 1'b0;
            ID_EX_IS_LOAD   <= 1'b0;
            ID_EX_IR        <= NOP;
        end else if (!HOLD) begin
            if (STALL) begin
                ID_EX_VALID     <= 1'b0;
                ID_EX_REG_WRITE <= 1'b0;
                ID_EX_IS_LOAD   <= 1'b0;
                ID_EX_IR        <= NOP;
            end else begin
                ID_EX_VALID     <= IF_ID_VALID;
                ID_EX_PC        <= IF_ID_PC;
                ID_EX_IR        <= IF_ID_IR;
                ID_EX_RS1       <= op1;
                ID_EX_RS2       <= op2;
                ID_EX_RD        <= rd;
                ID_EX_REG_WRITE <= IF_ID_VALID & reg_write;
                ID_EX_IS_LOAD   <= IF_ID_VALID & is_load;
            end
        end
    end

endmodule

// File: tb/tb_otter_decode_stage.sv
// tb/tb_otter_decode_stage.sv - table-driven and scoreboarded bench for otter_decode_stage
module tb_otter_decode_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IF_ID_VALID;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_IR;
    logic [4:0]  RF_ADR1;
    logic [4:0]  RF_ADR2;
    logic [31:0] RF_RS1;
    logic [31:0] RF_RS2;
    logic [31:0] EX_RESULT;
    logic [4:0]  MEM_RD;
    logic        MEM_REG_WRITE;
    logic [31:0] MEM_RESULT;
    logic        FLUSH;
    logic        HOLD;
    logic        STALL;
    logic        ID_EX_VALID;
    logic [31:0] ID_EX_PC;
    logic [31:0] ID_EX_IR;
    logic [31:0] ID_EX_RS1;
    logic [31:0] ID_EX_RS2;
    logic [4:0]  ID_EX_RD;
    logic        ID_EX_REG_WRITE;
    logic        ID_EX_IS_LOAD;

    otter_decode_stage #(.XLEN(32), .PC_RESET(32'h0)) dut (
        .CLK(CLK), .RST_N(RST_N), .IF_ID_VALID(IF_ID_VALID), .IF_ID_PC(IF_ID_PC),
        .IF_ID_IR(IF_ID_IR), .RF_ADR1(RF_ADR1), .RF_ADR2(RF_ADR2), .RF_RS1(RF_RS1),
        .RF_RS2(RF_RS2), .EX_RESULT(EX_RESULT), .MEM_RD(MEM_RD),
        .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RESULT(MEM_RESULT), .FLUSH(FLUSH),
        .HOLD(HOLD), .STALL(STALL), .ID_EX_VALID(ID_EX_VALID), .ID_EX_PC(ID_EX_PC),
        .ID_EX_IR(ID_EX_IR), .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2),
        .ID_EX_RD(ID_EX_RD), .ID_EX_REG_WRITE(ID_EX_REG_WRITE),
        .ID_EX_IS_LOAD(ID_EX_IS_LOAD)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] prev_ir;
        logic        cur_valid;
        logic [31:0] cur_ir;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [31:0] ex_res;
        logic [4:0]  mem_rd;
        logic        mem_w;
        logic [31:0] mem_res;
        logic        flush;
        logic        hold;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_ir;
        logic        chk_ops;
        logic        pc_prev;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_ld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[15];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] sub_i(input logic [4:0] rd, rs1, rs2);
        return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi_i(input logic [4:0] rd, rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw_i(input logic [4:0] rd, rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw_i(input logic [4:0] rs2, rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] lui_i(input logic [4:0] rd);
        return {20'h00001, rd, 7'b0110111};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] prev_ir, input logic cur_valid, input logic [31:0] cur_ir,
        input logic [31:0] rf1, rf2, ex_res, input logic [4:0] mem_rd, input logic mem_w,
        input logic [31:0] mem_res, input logic flush, hold, e_stall, e_valid,
        input logic [31:0] e_ir, input logic chk_ops, pc_prev,
        input logic [31:0] e_rs1, e_rs2, input logic [4:0] e_rd, input logic e_rw, e_ld);
        vec_t t;
        t = '{prev_ir, cur_valid, cur_ir, rf1, rf2, ex_res, mem_rd, mem_w, mem_res, flush,
              hold, e_stall, e_valid, e_ir, chk_ops, pc_prev, e_rs1, e_rs2, e_rd, e_rw, e_ld,
              32'h0};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, ir, rf1, rf2, ex_res,
                         input logic [4:0] mrd, input logic mw, input logic [31:0] mres,
                         input logic fl, ho);
        IF_ID_VALID = v; IF_ID_PC = pc; IF_ID_IR = ir; RF_RS1 = rf1; RF_RS2 = rf2;
        EX_RESULT = ex_res; MEM_RD = mrd; MEM_REG_WRITE = mw; MEM_RESULT = mres;
        FLUSH = fl; HOLD = ho;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(ID_EX_VALID), 32'h0);
        chk({tag, "_pc"}, ID_EX_PC, 32'h0);
        chk({tag, "_ir"}, ID_EX_IR, NOP);
        chk({tag, "_rs1"}, ID_EX_RS1, 32'h0);
        chk({tag, "_rs2"}, ID_EX_RS2, 32'h0);
        chk({tag, "_rd"}, 32'(ID_EX_RD), 32'h0);
        chk({tag, "_rw"}, 32'(ID_EX_REG_WRITE), 32'h0);
        chk({tag, "_ld"}, 32'(ID_EX_IS_LOAD), 32'h0);
        chk({tag, "_stall"}, 32'(STALL), 32'h0);
    endtask

    // Empty EX slot, then place the given instruction into EX.
    task automatic setup_ex(input logic [31:0] ir);
        drive(1'b0, 32'h0, NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h80, ir, 32'h1111, 32'h2222, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        vec_t e;
        logic [31:0] unk;
        unk = {20'd0, 5'd4, 7'h7f};

        vecs[0]  = mk(addi_i(5,1), 1, add_i(6,5,5), 0, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 1, add_i(6,5,5), 1, 0, 32'h1234, 32'h1234, 6, 1, 0);
        vecs[1]  = mk(addi_i(7,1), 1, add_i(10,7,2), 0, 32'h55, 32'hAA, 7, 1, 32'hBB, 0, 0, 0, 1, add_i(10,7,2), 1, 0, 32'hAA, 32'h55, 10, 1, 0);
        vecs[2]  = mk(addi_i(3,1), 1, add_i(10,7,7), 0, 0, 32'hAA, 7, 1, 32'hBB, 0, 0, 0, 1, add_i(10,7,7), 1, 0, 32'hBB, 32'hBB, 10, 1, 0);
        vecs[3]  = mk(addi_i(0,1), 1, add_i(11,0,0), 32'h77, 32'h77, 32'hDD, 0, 1, 32'hCC, 0, 0, 0, 1, add_i(11,0,0), 1, 0, 0, 0, 11, 1, 0);
        vecs[4]  = mk(lw_i(8,1), 1, sub_i(9,1,8), 32'h10, 32'h20, 32'h999, 0, 0, 0, 0, 0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(lw_i(8,1), 1, sw_i(3,8), 32'h10, 32'h20, 32'h999, 0, 0, 0, 0, 0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(lw_i(8,1), 1, lui_i(8), 32'h10, 32'h20, 32'h999, 0, 0, 0, 0, 0, 0, 1, lui_i(8), 1, 0, 0, 0, 8, 1, 0);
        vecs[7]  = mk(addi_i(5,1), 1, add_i(6,5,5), 0, 0, 32'h1234, 0, 0, 0, 1, 1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(lw_i(8,1), 1, sub_i(9,1,8), 32'h10, 32'h20, 32'h999, 0, 0, 0, 1, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(addi_i(5,1), 1, add_i(6,5,5), 0, 0, 32'h1234, 0, 0, 0, 0, 1, 0, 1, addi_i(5,1), 1, 1, 32'h1111, 0, 5, 1, 0);
        vecs[10] = mk(lw_i(8,1), 0, sub_i(9,1,8), 32'h10, 32'h20, 32'h999, 0, 0, 0, 0, 0, 0, 0, sub_i(9,1,8), 1, 0, 32'h10, 32'h20, 9, 0, 0);
        vecs[11] = mk(addi_i(5,1), 1, unk, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, unk, 1, 0, 0, 0, 4, 0, 0);
        vecs[12] = mk(addi_i(3,1), 1, lw_i(12,3), 0, 0, 32'h44, 0, 0, 0, 0, 0, 0, 1, lw_i(12,3), 1, 0, 32'h44, 0, 12, 1, 1);
        vecs[13] = mk(addi_i(3,1), 1, lw_i(0,1), 32'h66, 0, 0, 0, 0, 0, 0, 0, 0, 1, lw_i(0,1), 1, 0, 32'h66, 0, 0, 0, 1);
        vecs[14] = mk(lw_i(0,1), 1, add_i(9,0,0), 5, 5, 0, 0, 0, 0, 0, 0, 0, 1, add_i(9,0,0), 1, 0, 0, 0, 9, 1, 0);

        RST_N = 1'b0;
        drive(1'b1, 32'h40, add_i(6,5,5), 0, 0, 0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        chk_reset("por");
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 15; i++) begin
            e = vecs[i];
            setup_ex(e.prev_ir);
            e.e_pc = e.pc_prev ? 32'h80 : 32'h100 + 32'(i * 4);
            drive(e.cur_valid, 32'h100 + 32'(i * 4), e.cur_ir, e.rf1, e.rf2, e.ex_res,
                  e.mem_rd, e.mem_w, e.mem_res, e.flush, e.hold);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(STALL), 32'(e.e_stall));
            sb_q.push_back(e);
            tick();
            e = sb_q.pop_front();
            chk($sformatf("v%0d_valid", i), 32'(ID_EX_VALID), 32'(e.e_valid));
            chk($sformatf("v%0d_ir", i), ID_EX_IR, e.e_ir);
            chk($sformatf("v%0d_rw", i), 32'(ID_EX_REG_WRITE), 32'(e.e_rw));
            chk($sformatf("v%0d_ld", i), 32'(ID_EX_IS_LOAD), 32'(e.e_ld));
            if (e.chk_ops) begin
                chk($sformatf("v%0d_pc", i), ID_EX_PC, e.e_pc);
                chk($sformatf("v%0d_rs1", i), ID_EX_RS1, e.e_rs1);
                chk($sformatf("v%0d_rs2", i), ID_EX_RS2, e.e_rs2);
                chk($sformatf("v%0d_rd", i), 32'(ID_EX_RD), 32'(e.e_rd));
            end
        end

        // Load-use: exactly one bubble, then the loaded value arrives from MEM.
        setup_ex(lw_i(8,1));
        drive(1'b1, 32'h200, sub_i(9,1,8), 32'h10, 32'h0, 32'h999, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("lu_stall1", 32'(STALL), 32'h1);
        tick();
        chk("lu_bubble", 32'(ID_EX_VALID), 32'h0);
        drive(1'b1, 32'h200, sub_i(9,1,8), 32'h10, 32'h0, 32'h999, 5'd8, 1'b1, 32'hDEAD, 1'b0, 1'b0);
        #1 chk("lu_stall2", 32'(STALL), 32'h0);
        tick();
        chk("lu_valid", 32'(ID_EX_VALID), 32'h1);
        chk("lu_rs2", ID_EX_RS2, 32'hDEAD);
        chk("lu_rs1", ID_EX_RS1, 32'h10);
        chk("lu_pc", ID_EX_PC, 32'h200);

        // Asynchronous reset in the middle of a load-use condition.
        setup_ex(lw_i(8,1));
        drive(1'b1, 32'h300, sub_i(9,1,8), 32'h10, 32'h20, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("rst_pre_stall", 32'(STALL), 32'h1);
        RST_N = 1'b0;
        #1 chk_reset("arst");
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("arst_rel_valid", 32'(ID_EX_VALID), 32'h1);
        chk("arst_rel_ir", ID_EX_IR, sub_i(9,1,8));
        chk("arst_rel_rs2", ID_EX_RS2, 32'h20);
        chk("arst_rel_pc", ID_EX_PC, 32'h300);

        // Freeze for three cycles while IF/ID keeps changing.
        setup_ex(addi_i(5,1));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 32'(k), add_i(5'(6 + k), 5, 5), 32'(k), 32'(k + 1),
                  32'h5000 + 32'(k), 5'd5, 1'b1, 32'h6000, 1'b0, 1'b1);
            tick();
            chk($sformatf("hold%0d_valid", k), 32'(ID_EX_VALID), 32'h1);
            chk($sformatf("hold%0d_ir", k), ID_EX_IR, addi_i(5,1));
            chk($sformatf("hold%0d_pc", k), ID_EX_PC, 32'h80);
            chk($sformatf("hold%0d_rs1", k), ID_EX_RS1, 32'h1111);
            chk($sformatf("hold%0d_rd", k), 32'(ID_EX_RD), 32'h5);
        end
        drive(1'b1, 32'h500, add_i(6,5,5), 32'h0, 32'h0, 32'h1234, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("unhold_ir", ID_EX_IR, add_i(6,5,5));
        chk("unhold_rs1", ID_EX_RS1, 32'h1234);
        chk("unhold_pc", ID_EX_PC, 32'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/otter_decode_stage.md
Name: otter_decode_stage

Overview:
- Decode/operand stage of the 5-stage OTTER pipeline, directly upstream of the register file read and feeding EX.
- Splits the IF/ID instruction into register addresses and drives the register-file read ports.
- Forwards in-flight EX/MEM results over the register-file data, detects load-use hazards, and latches everything into the ID/EX pipeline register.
- Handles flush (bubble) and hold (freeze).

Parameters:
- XLEN, 32, datapath width
- PC_RESET, 32'h0000_0000, ID_EX_PC value after reset

Ports:
- CLK  input  1  system clock; all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- IF_ID_VALID  input  1  IF/ID slot holds a real instruction
- IF_ID_PC  input  XLEN  PC of the IF/ID instruction
- IF_ID_IR  input  32  instruction word
- RF_ADR1  output  5  register-file read address 1 = IF_ID_IR[19:15]
- RF_ADR2  output  5  register-file read address 2 = IF_ID_IR[24:20]
- RF_RS1  input  XLEN  register-file read data 1 (x0 already reads 0)
- RF_RS2  input  XLEN  register-file read data 2
- EX_RESULT  input  XLEN  ALU result of the instruction currently in EX
- MEM_RD  input  5  destination register of the instruction in MEM
- MEM_REG_WRITE  input  1  MEM instruction writes a register (valid-qualified upstream)
- MEM_RESULT  input  XLEN  final MEM-stage value (load data or ALU result)
- FLUSH  input  1  taken branch/jump resolved in EX; kill the IF/ID instruction
- HOLD  input  1  global freeze (memory wait); ID/EX retains its contents
- STALL  output  1  load-use stall request to PC/IF-ID; combinational
- ID_EX_VALID  output  1  EX slot holds a real instruction
- ID_EX_PC  output  XLEN  latched PC
- ID_EX_IR  output  32  latched instruction
- ID_EX_RS1  output  XLEN  forwarded operand 1
- ID_EX_RS2  output  XLEN  forwarded operand 2
- ID_EX_RD  output  5  destination register = IR[11:7]
- ID_EX_REG_WRITE  output  1  EX instruction writes rd (0 if rd==0)
- ID_EX_IS_LOAD  output  1  EX instruction is a LOAD (opcode 0000011)

Behaviour:
- Reset (RST_N=0, asynchronous):
  - ID_EX_VALID, ID_EX_REG_WRITE and ID_EX_IS_LOAD = 0.
  - ID_EX_PC = PC_RESET.
  - ID_EX_IR = 32'h0000_0013 (NOP).
  - ID_EX_RS1, ID_EX_RS2 and ID_EX_RD = 0.
  - STALL is 0 while ID_EX_VALID = 0.
- Decode (combinational):
  - Use flags use_rs1 for opcodes JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM.
  - Use flags use_rs2 for opcodes BRANCH, STORE, OP.
  - reg_write for opcodes LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM, and only when rd≠0.
  - Unknown opcode: reg_write=0, no use flags.
- Forwarding, per operand n∈{1,2} with address a:
  - If a==0, the operand is 0.
  - Else if ID_EX_VALID & ID_EX_REG_WRITE & ~ID_EX_IS_LOAD & ID_EX_RD==a, the operand is EX_RESULT.
  - Else if MEM_REG_WRITE & MEM_RD==a, the operand is MEM_RESULT.
  - Else the operand is RF_RSn.
  - EX priority is higher than MEM.
  - No WB bypass: the register file writes on the falling edge, so the WB value is visible in RF_RSn before the rising edge.
- Load-use hazard:
  - load_use = IF_ID_VALID & ID_EX_VALID & ID_EX_IS_LOAD & ID_EX_REG_WRITE & ((use_rs1 & rs1==ID_EX_RD) | (use_rs2 & rs2==ID_EX_RD)).
  - STALL = load_use & ~FLUSH.
  - Exactly one bubble per load-use; next cycle the load is in MEM and the value comes from MEM_RESULT.
- Rising-edge update priority:
  - 1. FLUSH=1: ID_EX_VALID<=0, REG_WRITE<=0, IS_LOAD<=0, IR<=NOP. This applies even when HOLD=1.
  - 2. HOLD=1: all ID/EX registers keep their value.
  - 3. STALL=1: insert a bubble (VALID/REG_WRITE/IS_LOAD<=0, IR<=NOP). Upstream holds IF/ID and PC.
  - 4. Otherwise:
    - VALID<=IF_ID_VALID.
    - PC, IR, RS1, RS2 and RD are latched.
    - REG_WRITE<=IF_ID_VALID & reg_write.
    - IS_LOAD<=IF_ID_VALID & (opcode==LOAD).
- Latency: one cycle from IF/ID to ID/EX. Operands are resolved in the same cycle as the RF read.
- An invalid IF/ID slot (IF_ID_VALID=0) never stalls and never writes.

Test Plan:
- Reset: hold RST_N=0 mid-stream with IF_ID_VALID=1 → all ID/EX outputs take reset values immediately and asynchronously, with ID_EX_IR=32'h13 and STALL=0. After release, the first edge latches normally.
- EX forward: EX holds addi x5 (REG_WRITE=1, IS_LOAD=0) with EX_RESULT=32'h1234; IF/ID holds add x6,x5,x5; RF_RS1=RF_RS2=0 → ID_EX_RS1=ID_EX_RS2=32'h1234 after the edge.
- EX vs MEM priority: EX writes x7=32'hAA; MEM_RD=7, MEM_REG_WRITE=1, MEM_RESULT=32'hBB → operand=32'hAA. Remove the EX match → operand=32'hBB. Use x0 with every source matching → operand=0.
- Load-use: EX holds lw x8; IF/ID holds sub x9,x1,x8 → STALL=1 for exactly one cycle and ID_EX_VALID=0 next cycle. The following cycle MEM_RESULT=32'hDEAD reaches ID_EX_RS2 with VALID=1. A store using x8 only as rs1 also stalls; `lui x8` after a load does not stall.
- Flush vs hold/stall: FLUSH=1 together with HOLD=1 → VALID=0 next edge. FLUSH=1 with a load-use condition → STALL=0 and a bubble is latched.
- Hold: HOLD=1 for 3 cycles while the IF/ID inputs change → the ID/EX outputs stay bit-identical. After HOLD drops, the current IF/ID is latched.
